// File: rtl/ofm_pack_writer_pkg.sv
// Shared types and defaults for the output feature-map pack writer.
package ofm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ofm_state_e;

    localparam int OFM_PACK_DEF   = 4;
    localparam int OFM_ADDR_W_DEF = 16;

    // Lane counter must be at least one bit wide even when PACK == 1.
    function automatic int lane_w(input int pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

endpackage

// File: rtl/ofm_pack_writer.sv
// Packs PACK signed result elements per memory word and issues addressed word writes.
// Optional stall counter output is enabled by defining OFM_STALL_CNT_EN.
module ofm_pack_writer
    import ofm_pkg::*;
#(
    parameter int IN_BITS = 32,
    parameter int PACK    = OFM_PACK_DEF,
    parameter int ADDR_W  = OFM_ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_start,
    input  logic [ADDR_W-1:0]       cfg_base_addr,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_BITS-1:0]      in_data,
    input  logic                    in_last,
    output logic                    mem_wr_valid,
    input  logic                    mem_wr_ready,
    output logic [ADDR_W-1:0]       mem_wr_addr,
    output logic [IN_BITS*PACK-1:0] mem_wr_data,
    output logic [PACK-1:0]         mem_wr_strb,
    output logic                    mem_wr_last
`ifdef OFM_STALL_CNT_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);

    localparam int LANE_W = lane_w(PACK);
    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(PACK - 1);

    ofm_state_e              state_q, state_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [IN_BITS*PACK-1:0] data_q, data_d;
    logic [PACK-1:0]         strb_q, strb_d;
    logic                    last_q, last_d;
`ifdef OFM_STALL_CNT_EN
    logic [31:0]             stall_q, stall_d;
`endif

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        data_d  = data_q;
        strb_d  = strb_q;
        last_d  = last_q;
`ifdef OFM_STALL_CNT_EN
        stall_d = stall_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_RUN;
                    addr_d  = cfg_base_addr;
                    lane_d  = '0;
                    data_d  = '0;
                    strb_d  = '0;
                    last_d  = 1'b0;
`ifdef OFM_STALL_CNT_EN
                    stall_d = '0;
`endif
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    data_d[int'(lane_q)*IN_BITS +: IN_BITS] = in_data;
                    strb_d[lane_q] = 1'b1;
                    last_d         = in_last;
                    if (lane_q == LANE_MAX || in_last) begin
                        state_d = ST_WRITE;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_wr_ready) begin
                    // Address wraps naturally at ADDR_W bits.
                    addr_d  = addr_q + 1'b1;
                    lane_d  = '0;
                    data_d  = '0;
                    strb_d  = '0;
                    last_d  = 1'b0;
                    state_d = last_q ? ST_DONE : ST_RUN;
                end
`ifdef OFM_STALL_CNT_EN
                else if (stall_q != '1) begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
`ifdef OFM_STALL_CNT_EN
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
`ifdef OFM_STALL_CNT_EN
            stall_q <= stall_d;
`endif
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign in_ready     = (state_q == ST_RUN);
    assign mem_wr_valid = (state_q == ST_WRITE);
    assign mem_wr_addr  = addr_q;
    assign mem_wr_data  = data_q;
    assign mem_wr_strb  = strb_q;
    assign mem_wr_last  = last_q;
`ifdef OFM_STALL_CNT_EN
    assign stall_cnt    = stall_q;
`endif

endmodule

// File: tb/tb_ofm_pack_writer.sv
// Directed bench for ofm_pack_writer (PACK=4, IN_BITS=32, ADDR_W=16).
module tb_ofm_pack_writer;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_start;
    logic [15:0]  cfg_base_addr;
    logic         busy, done;
    logic         in_valid, in_ready, in_last;
    logic [31:0]  in_data;
    logic         mem_wr_valid, mem_wr_ready, mem_wr_last;
    logic [15:0]  mem_wr_addr;
    logic [127:0] mem_wr_data;
    logic [3:0]   mem_wr_strb;
`ifdef OFM_STALL_CNT_EN
    logic [31:0]  stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0]  wa[$];
    logic [127:0] wd[$];
    logic [3:0]   ws[$];
    logic         wl[$];

    always #5 clk = ~clk;

    ofm_pack_writer #(.IN_BITS(32), .PACK(4), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_strb(mem_wr_strb), .mem_wr_last(mem_wr_last)
`ifdef OFM_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Record every write handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_wr_valid && mem_wr_ready) begin
            wa.push_back(mem_wr_addr);
            wd.push_back(mem_wr_data);
            ws.push_back(mem_wr_strb);
            wl.push_back(mem_wr_last);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] base);
        cfg_base_addr = base;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        t = 0;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        chk("push_timeout", {127'd0, (t < 50)}, 128'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 50) begin
            step();
            t++;
        end
        chk("done_seen", {127'd0, done}, 128'd1);
        chk("busy_at_done", {127'd0, busy}, 128'd1);
        step();
        chk("done_pulse_end", {127'd0, done}, 128'd0);
        chk("busy_fall", {127'd0, busy}, 128'd0);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [15:0] a,
                          input logic [127:0] d, input logic [3:0] s, input logic l);
        if (idx < wa.size()) begin
            chk({tag, "_addr"}, {112'd0, wa[idx]}, {112'd0, a});
            chk({tag, "_data"}, wd[idx], d);
            chk({tag, "_strb"}, {124'd0, ws[idx]}, {124'd0, s});
            chk({tag, "_last"}, {127'd0, wl[idx]}, {127'd0, l});
        end else begin
            chk({tag, "_present"}, 128'(wa.size()), 128'(idx + 1));
        end
    endtask

    initial begin
        int b;
        rst = 1'b1; cfg_start = 1'b0; cfg_base_addr = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; mem_wr_ready = 1'b1;
        repeat (3) step();

        // Reset state
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
        chk("rst_valid", {127'd0, mem_wr_valid}, 128'd0);
        chk("rst_addr", {112'd0, mem_wr_addr}, 128'd0);
        chk("rst_data", mem_wr_data, 128'd0);
        chk("rst_strb", {124'd0, mem_wr_strb}, 128'd0);
        chk("rst_last", {127'd0, mem_wr_last}, 128'd0);
        rst = 1'b0;
        step();

        // Input offered while idle is not accepted
        in_valid = 1'b1; in_data = 32'd99;
        repeat (3) begin
            step();
            chk("idle_in_ready", {127'd0, in_ready}, 128'd0);
        end
        in_valid = 1'b0;
        chk("idle_no_write", 128'(wa.size()), 128'd0);

        // Full words
        b = wa.size();
        start(16'h0010);
        chk("start_busy", {127'd0, busy}, 128'd1);
        chk("start_in_ready", {127'd0, in_ready}, 128'd1);
        for (int i = 1; i <= 4; i++) push(32'(i), 1'b0);
        chk("lat_valid", {127'd0, mem_wr_valid}, 128'd1);
        chk("lat_in_ready", {127'd0, in_ready}, 128'd0);
        for (int i = 5; i <= 8; i++) push(32'(i), i == 8);
        wait_done();
        chk("full_count", 128'(wa.size() - b), 128'd2);
        chk_wr("full_w0", b, 16'h0010,
               {32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111, 1'b0);
        chk_wr("full_w1", b + 1, 16'h0011,
               {32'd8, 32'd7, 32'd6, 32'd5}, 4'b1111, 1'b1);

        // Partial final word, with a start pulse mid-tile that must be ignored
        b = wa.size();
        start(16'h0020);
        push(32'd10, 1'b0);
        push(32'd11, 1'b0);
        cfg_base_addr = 16'h5555; cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int i = 12; i <= 15; i++) push(32'(i), i == 15);
        wait_done();
        chk("part_count", 128'(wa.size() - b), 128'd2);
        chk_wr("part_w0", b, 16'h0020,
               {32'd13, 32'd12, 32'd11, 32'd10}, 4'b1111, 1'b0);
        chk_wr("part_w1", b + 1, 16'h0021,
               {32'd0, 32'd0, 32'd15, 32'd14}, 4'b0011, 1'b1);

        // Backpressure on the first word
        b = wa.size();
        mem_wr_ready = 1'b0;
        start(16'h0030);
        for (int i = 1; i <= 4; i++) push(32'(i), 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", {127'd0, mem_wr_valid}, 128'd1);
            chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
            chk("bp_addr", {112'd0, mem_wr_addr}, 128'h30);
            chk("bp_data", mem_wr_data, {32'd4, 32'd3, 32'd2, 32'd1});
            chk("bp_strb", {124'd0, mem_wr_strb}, 128'hf);
            step();
        end
        mem_wr_ready = 1'b1;
        step();
`ifdef OFM_STALL_CNT_EN
        chk("bp_stall_cnt", {96'd0, stall_cnt}, 128'd5);
`endif
        push(32'd5, 1'b1);
        wait_done();
`ifdef OFM_STALL_CNT_EN
        chk("bp_stall_hold", {96'd0, stall_cnt}, 128'd5);
`endif
        chk("bp_count", 128'(wa.size() - b), 128'd2);
        chk_wr("bp_w0", b, 16'h0030,
               {32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111, 1'b0);
        chk_wr("bp_w1", b + 1, 16'h0031,
               {32'd0, 32'd0, 32'd0, 32'd5}, 4'b0001, 1'b1);

        // Address wrap, signed elements
        b = wa.size();
        start(16'hFFFF);
        push(32'hFFFF_FFFF, 1'b0);
        push(32'hFFFF_FFFE, 1'b0);
        push(32'hFFFF_FFFD, 1'b0);
        push(32'hFFFF_FFFC, 1'b0);
        for (int i = 5; i <= 8; i++) push(32'(i), i == 8);
        wait_done();
        chk_wr("wrap_w0", b, 16'hFFFF,
               {32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF}, 4'b1111, 1'b0);
        chk_wr("wrap_w1", b + 1, 16'h0000,
               {32'd8, 32'd7, 32'd6, 32'd5}, 4'b1111, 1'b1);

        // Mid-tile reset, then a fresh tile
        b = wa.size();
        start(16'h0040);
        push(32'd7, 1'b0);
        push(32'd9, 1'b0);
        rst = 1'b1;
        step();
        chk("mrst_busy", {127'd0, busy}, 128'd0);
        chk("mrst_in_ready", {127'd0, in_ready}, 128'd0);
        chk("mrst_valid", {127'd0, mem_wr_valid}, 128'd0);
        chk("mrst_addr", {112'd0, mem_wr_addr}, 128'd0);
        chk("mrst_data", mem_wr_data, 128'd0);
        chk("mrst_strb", {124'd0, mem_wr_strb}, 128'd0);
        chk("mrst_last", {127'd0, mem_wr_last}, 128'd0);
        chk("mrst_done", {127'd0, done}, 128'd0);
        rst = 1'b0;
        step();
        chk("mrst_no_write", 128'(wa.size() - b), 128'd0);
        start(16'h0050);
        for (int i = 1; i <= 4; i++) push(32'(i), i == 4);
        wait_done();
        chk("after_rst_count", 128'(wa.size() - b), 128'd1);
        chk_wr("after_rst_w0", b, 16'h0050,
               {32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
